// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped user I/O device behind the data-memory decoder.
// Holds the output port register and its write strobe and counter. Synchronizes
// the two asynchronous user inputs and steers load data by mux_sel. Each input
// port keeps a sticky change flag.
// Build option: define IO_DEBOUNCE_EN to add a per-port debounce filter of
// DEBOUNCE_CYCLES stable cycles. Without it the synchronizer output is used directly.
module io_port_bank #(
    parameter int DATA_W          = 32,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              out_en,
    input  logic [1:0]        mux_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] in_port0,
    input  logic [DATA_W-1:0] in_port1,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_port,
    output logic              out_strobe,
    output logic [7:0]        out_count,
    output logic [1:0]        in_changed
);

    logic [DATA_W-1:0] in_raw [2];
    logic [DATA_W-1:0] sync1  [2];
    logic [DATA_W-1:0] sync2  [2];
    logic [DATA_W-1:0] stbl   [2];
    logic [1:0]        stbl_load;
    logic [1:0]        sel_hit;

    assign in_raw[0] = in_port0;
    assign in_raw[1] = in_port1;

    // A load from port i is in progress when the decoder selects it.
    assign sel_hit = {mux_sel == 2'b10, mux_sel == 2'b01};

    // Two-flop synchronizers bring the asynchronous inputs into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync1[i] <= '0;
                sync2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync1[i] <= in_raw[i];
                sync2[i] <= sync1[i];
            end
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] s2_d [2];
    logic [7:0]        cnt  [2];
    logic [1:0]        cnt_inc;

    // A new value is counted only while it is unchanged and differs from the accepted value.
    always_comb begin
        cnt_inc   = '0;
        stbl_load = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_inc[i]   = (sync2[i] == s2_d[i]) && (sync2[i] != stbl[i]);
            stbl_load[i] = cnt_inc[i] && (cnt[i] == CNT_LAST);
        end
    end

    // Debounce filter: accept sync2 after DEBOUNCE_CYCLES consecutive stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                s2_d[i] <= '0;
                cnt[i]  <= '0;
                stbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                s2_d[i] <= sync2[i];
                if (stbl_load[i]) begin
                    stbl[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (cnt_inc[i]) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    // The second synchronizer flop is the accepted value; it changes whenever sync1 differs.
    always_comb begin
        stbl_load = '0;
        for (int i = 0; i < 2; i++) begin
            stbl[i]      = sync2[i];
            stbl_load[i] = (sync1[i] != sync2[i]);
        end
    end
`endif

    // Sticky change flags: a new accepted value sets the flag and beats a same-edge read clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_changed <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (stbl_load[i]) begin
                    in_changed[i] <= 1'b1;
                end else if (sel_hit[i]) begin
                    in_changed[i] <= 1'b0;
                end
            end
        end
    end

    // Load data steering back to the datapath.
    always_comb begin
        rd_data = '0;
        case (mux_sel)
            2'b00:   rd_data = mem_rdata;
            2'b01:   rd_data = stbl[0];
            2'b10:   rd_data = stbl[1];
            default: rd_data = '0;
        endcase
    end

    // Output port register, one-cycle write strobe and wrapping write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_port   <= '0;
            out_strobe <= 1'b0;
            out_count  <= '0;
        end else begin
            out_strobe <= out_en;
            if (out_en) begin
                out_port  <= wr_data;
                out_count <= out_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: scoreboard bench for io_port_bank. Expected values are queued
// when stimulus is applied and popped when the DUT result is sampled.
module tb_io_port_bank;

    localparam int DATA_W = 32;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 2;
`endif

    logic              clk;
    logic              rst_n;
    logic              out_en;
    logic [1:0]        mux_sel;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] in_port0;
    logic [DATA_W-1:0] in_port1;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_port;
    logic              out_strobe;
    logic [7:0]        out_count;
    logic [1:0]        in_changed;

    io_port_bank #(.DATA_W(DATA_W), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_en     (out_en),
        .mux_sel    (mux_sel),
        .wr_data    (wr_data),
        .mem_rdata  (mem_rdata),
        .in_port0   (in_port0),
        .in_port1   (in_port1),
        .rd_data    (rd_data),
        .out_port   (out_port),
        .out_strobe (out_strobe),
        .out_count  (out_count),
        .in_changed (in_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compareCount  = 0;
    int          mismatchCount = 0;
    string       tagQ[$];
    logic [31:0] expQ[$];
    logic [7:0]  modelCount;
    logic [31:0] modelOut;
    logic [31:0] peekValue;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectValue(input string tag, input logic [31:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    task automatic compareNext(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        if (expQ.size() == 0) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL scoreboard_empty: got %h expected nothing", observed);
        end else begin
            tag      = tagQ.pop_front();
            expected = expQ.pop_front();
            checkOutput(tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Look at a port through rd_data without leaving it selected across an edge.
    task automatic peekPort(input logic [1:0] sel, output logic [31:0] value);
        logic [1:0] saved;
        saved   = mux_sel;
        mux_sel = sel;
        #1;
        value   = rd_data;
        mux_sel = saved;
    endtask

    // Drive one write-port cycle and queue the model's view of the next edge.
    task automatic applyStimulus(input logic en, input logic [31:0] data);
        out_en  = en;
        wr_data = data;
        if (en) begin
            modelOut   = data;
            modelCount = modelCount + 8'd1;
        end
        expectValue("out_port", modelOut);
        expectValue("out_strobe", 32'(en));
        expectValue("out_count", 32'(modelCount));
    endtask

    task automatic writeCycle(input logic en, input logic [31:0] data);
        applyStimulus(en, data);
        step(1);
        compareNext(out_port);
        compareNext(32'(out_strobe));
        compareNext(32'(out_count));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        out_en     = 1'b0;
        mux_sel    = 2'b11;
        wr_data    = '0;
        mem_rdata  = '0;
        in_port0   = '0;
        in_port1   = '0;
        modelCount = '0;
        modelOut   = '0;
        step(2);

        expectValue("reset_out_port", 32'h0);   compareNext(out_port);
        expectValue("reset_out_strobe", 32'h0); compareNext(32'(out_strobe));
        expectValue("reset_out_count", 32'h0);  compareNext(32'(out_count));
        expectValue("reset_in_changed", 32'h0); compareNext(32'(in_changed));
        expectValue("reset_rd_none", 32'h0);    compareNext(rd_data);
        rst_n = 1'b1;
        step(1);

        $display("[TB] single write");
        writeCycle(1'b1, 32'hDEADBEEF);
        writeCycle(1'b0, 32'h0);

        $display("[TB] 256 back-to-back writes");
        for (int i = 0; i < 256; i++) begin
            writeCycle(1'b1, 32'(i) ^ 32'h5A5A0000);
        end
        writeCycle(1'b0, 32'h0);

        $display("[TB] asynchronous reset mid-run");
        writeCycle(1'b1, 32'h1234);
        #1;
        rst_n = 1'b0;
        #1;
        expectValue("areset_out_port", 32'h0);   compareNext(out_port);
        expectValue("areset_out_strobe", 32'h0); compareNext(32'(out_strobe));
        expectValue("areset_out_count", 32'h0);  compareNext(32'(out_count));
        out_en     = 1'b0;
        modelCount = '0;
        modelOut   = '0;
        rst_n      = 1'b1;
        step(1);

        $display("[TB] read mux sweep");
        mem_rdata = 32'hAAAA0000;
        in_port0  = 32'h5;
        in_port1  = 32'h9;
        step(LAT + 2);
        expectValue("flags_after_settle", 32'h3); compareNext(32'(in_changed));
        mux_sel = 2'b00; #1;
        expectValue("rd_ram", 32'hAAAA0000); compareNext(rd_data);
        step(1);
        mux_sel = 2'b01; #1;
        expectValue("rd_port0", 32'h5); compareNext(rd_data);
        step(1);
        mux_sel = 2'b10; #1;
        expectValue("rd_port1", 32'h9); compareNext(rd_data);
        step(1);
        mux_sel = 2'b11; #1;
        expectValue("rd_none", 32'h0); compareNext(rd_data);
        step(1);
        expectValue("flags_after_reads", 32'h0); compareNext(32'(in_changed));

        $display("[TB] change flag on port 1");
        in_port1 = 32'h0;
        step(LAT + 1);
        mux_sel = 2'b10;
        step(1);
        mux_sel = 2'b11;
        expectValue("flag1_cleared_pre", 32'h0); compareNext(32'(in_changed));
        in_port1 = 32'h7;
        step(LAT - 1);
        peekPort(2'b10, peekValue);
        expectValue("port1_before_latency", 32'h0); compareNext(peekValue);
        expectValue("flag1_before_latency", 32'h0); compareNext(32'(in_changed[1]));
        step(1);
        peekPort(2'b10, peekValue);
        expectValue("port1_at_latency", 32'h7); compareNext(peekValue);
        expectValue("flag1_at_latency", 32'h1); compareNext(32'(in_changed[1]));
        mux_sel = 2'b10;
        step(1);
        mux_sel = 2'b11;
        expectValue("flag1_read_clear", 32'h0); compareNext(32'(in_changed[1]));

        in_port1 = 32'hC;
        step(LAT - 1);
        mux_sel = 2'b10;
        step(1);
        expectValue("flag1_set_wins", 32'h1); compareNext(32'(in_changed[1]));
        expectValue("port1_set_wins", 32'hC); compareNext(rd_data);
        mux_sel = 2'b11;
        step(1);
        expectValue("flag1_still_set", 32'h1); compareNext(32'(in_changed[1]));

        $display("[TB] glitch on port 0");
`ifdef IO_DEBOUNCE_EN
        in_port0 = 32'hA;
        step(3);
        in_port0 = 32'h5;
        step(12);
        peekPort(2'b01, peekValue);
        expectValue("port0_glitch_filtered", 32'h5); compareNext(peekValue);
        expectValue("flag0_glitch_filtered", 32'h0); compareNext(32'(in_changed[0]));
`else
        in_port0 = 32'hA;
        step(1);
        in_port0 = 32'h5;
        step(4);
        peekPort(2'b01, peekValue);
        expectValue("port0_after_glitch", 32'h5); compareNext(peekValue);
        expectValue("flag0_glitch_passes", 32'h1); compareNext(32'(in_changed[0]));
`endif

        if (expQ.size() != 0) begin
            checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
